// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// One full-adder cell (two half adders plus an OR) is reused for WIDTH
// cycles, LSB first, with a carry flip-flop between bits. Operands are
// accepted on an in_valid/in_ready handshake. The result is offered on an
// out_valid/out_ready handshake.
// Optional build macro: SERIAL_ADD_SUB_EN adds a `sub` input that selects
// two's-complement subtraction (a - b) for the job being accepted.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] sum_sr_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic [1:0]       ha0;
  logic [1:0]       ha1;
  logic             bit_s;
  logic             bit_c;

  // Half-adder cell: returns {carry, sum}.
  function automatic logic [1:0] halfadder(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Operand B as loaded into the shift register, and the carry-in for the job.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    b_load   = sub ? ~b : b;
    cin_load = sub;
`else
    b_load   = b;
    cin_load = 1'b0;
`endif
  end

  // Full adder assembled from two half adders and an OR, fed by the LSBs.
  always_comb begin
    ha0   = halfadder(a_sr_reg[0], b_sr_reg[0]);
    ha1   = halfadder(ha0[0], carry_reg);
    bit_s = ha1[0];
    bit_c = ha0[1] | ha1[1];
  end

  // Controller FSM and the serial datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      sum_sr_reg <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b_load;
            carry_reg <= cin_load;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // New bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
          sum_sr_reg <= {bit_s, sum_sr_reg[WIDTH-1:1]};
          a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
          carry_reg  <= bit_c;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            cout_reg  <= bit_c;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it; the handoff edge
          // never accepts a new job, which forces one idle cycle between jobs.
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake and status outputs decode directly from the state.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
    sum       = sum_sr_reg;
    cout      = cout_reg;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8). Table-driven add vectors plus
// hand-written sequences for backpressure, reset mid-job and back-to-back
// requests. Subtraction vectors are included when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one job with out_ready=1 starting from IDLE; returns latency in
  // clock edges after the accept edge, and the result. Ends at the negedge
  // where out_valid was first seen (the handoff edge comes next).
  task automatic run_job(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                         output int lat, output logic [W-1:0] s, output logic c);
    @(negedge clk);
    a = ta;
    b = tb_b;
`ifdef SERIAL_ADD_SUB_EN
    sub = ts;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s = sum;
    c = cout;
    $display("job a=%0d b=%0d sub=%0b -> sum=%0d cout=%0b latency=%0d", ta, tb_b, ts, s, c, lat);
  endtask

  initial begin
    int lat;
    logic [W-1:0] s;
    logic c;

    vecs.push_back('{8'd100, 8'd27,  1'b0, 8'd127, 1'b0});
    vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd0,   1'b1});
    vecs.push_back('{8'd0,   8'd0,   1'b0, 8'd0,   1'b0});
    vecs.push_back('{8'd200, 8'd100, 1'b0, 8'd44,  1'b1});
    vecs.push_back('{8'd170, 8'd85,  1'b0, 8'd255, 1'b0});
    vecs.push_back('{8'd128, 8'd128, 1'b0, 8'd0,   1'b1});
    vecs.push_back('{8'd15,  8'd241, 1'b0, 8'd0,   1'b1});
    vecs.push_back('{8'd3,   8'd4,   1'b0, 8'd7,   1'b0});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'd10,  8'd3,   1'b1, 8'd7,   1'b1});
    vecs.push_back('{8'd5,   8'd7,   1'b1, 8'hFE,  1'b0});
    vecs.push_back('{8'd0,   8'd0,   1'b1, 8'd0,   1'b1});
    vecs.push_back('{8'd9,   8'd9,   1'b0, 8'd18,  1'b0});
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      run_job(vecs[i].va, vecs[i].vb, vecs[i].vsub, lat, s, c);
      check($sformatf("vec%0d latency", i), lat, W);
      check($sformatf("vec%0d sum", i), s, vecs[i].exp_sum);
      check($sformatf("vec%0d cout", i), c, vecs[i].exp_cout);
    end

    // Backpressure: hold out_ready low for 5 cycles in DONE
    @(negedge clk);
    a = 8'd100;
    b = 8'd27;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    a = 8'd1;
    b = 8'd1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", lat, W);
    for (int k = 0; k < 5; k++) begin
      a = 8'(k * 7);
      b = 8'(k + 50);
      @(negedge clk);
      check($sformatf("bp%0d out_valid", k), out_valid, 1);
      check($sformatf("bp%0d sum", k), sum, 127);
      check($sformatf("bp%0d cout", k), cout, 0);
      check($sformatf("bp%0d in_ready", k), in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", out_valid, 0);
    check("bp release in_ready", in_ready, 1);
    check("bp release busy", busy, 0);
    check("bp retained sum", sum, 127);
    $display("backpressure sequence done sum=%0d", sum);

    // Reset in the middle of a job
    @(negedge clk);
    a = 8'd200;
    b = 8'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst busy before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst in_ready", in_ready, 1);
    check("midrst out_valid", out_valid, 0);
    check("midrst sum", sum, 0);
    check("midrst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_job(8'd3, 8'd4, 1'b0, lat, s, c);
    check("postrst latency", lat, W);
    check("postrst sum", s, 7);
    check("postrst cout", c, 0);

    // Back-to-back: in_valid held high, jobs accepted every 10 edges
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 30; k++) begin
      case (k)
        0:  begin a = 8'd1;   b = 8'd2;  end
        10: begin a = 8'd50;  b = 8'd60; end
        20: begin a = 8'd250; b = 8'd10; end
        default: begin a = 8'hA5 ^ 8'(k); b = 8'(k * 3); end
      endcase
      @(negedge clk);
      if (k % 10 == 8) begin
        check($sformatf("b2b%0d out_valid", k / 10), out_valid, 1);
        check($sformatf("b2b%0d sum", k / 10), sum, (k < 10) ? 3 : (k < 20) ? 110 : 4);
        check($sformatf("b2b%0d cout", k / 10), cout, (k >= 20) ? 1 : 0);
        $display("b2b job %0d sum=%0d cout=%0b", k / 10, sum, cout);
      end else if (k % 10 == 9) begin
        check($sformatf("b2b%0d idle in_ready", k / 10), in_ready, 1);
        check($sformatf("b2b%0d idle busy", k / 10), busy, 0);
      end else begin
        check($sformatf("b2b%0d k%0d out_valid", k / 10, k), out_valid, 0);
      end
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
